// File: rtl/instr_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_dispatch_if
// Purpose  : Buffer-side and backend-side signal bundle for instr_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_dispatch_if #(
  parameter int DATA_W  = 64,
  parameter int CREDITS = 8
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  // Lane word: bit 0 = valid, [DATA_W:1] = payload
  logic [1:0][DATA_W:0] i_instrs;
  logic                 o_dequeue;
  logic                 i_flush;
  logic                 i_be_stall;
  logic [1:0]           i_credit_ret;
  logic [1:0][DATA_W:0] o_instrs;
  logic [CNT_W-1:0]     o_credits;

  modport slave (
    input  i_instrs, i_flush, i_be_stall, i_credit_ret,
    output o_dequeue, o_instrs, o_credits
  );

  modport master (
    output i_instrs, i_flush, i_be_stall, i_credit_ret,
    input  o_dequeue, o_instrs, o_credits
  );
endinterface
`default_nettype wire

// File: rtl/instr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : instr_dispatch
// Purpose  : Two-slot in-order dispatcher, credit and stall gated, with lane
//            compaction. Optional counters enabled by DISPATCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_dispatch #(
  parameter int DATA_W  = 64,
  parameter int CREDITS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  instr_dispatch_if.slave    bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]        o_stat_disp,
  output logic [31:0]        o_stat_cstall
`endif
);
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] C_CREDITS     = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] C_TWO         = CNT_W'(2);
  localparam logic [CNT_W:0]   C_CREDITS_EXT = (CNT_W + 1)'(CREDITS);

  logic [1:0]             hold_v_q, hold_v_d;
  logic [1:0][DATA_W-1:0] hold_pl_q, hold_pl_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   w_iss0, w_iss1, w_drain, w_dequeue;
  logic [CNT_W:0]         w_cnt_sum;

  always_comb begin
    w_iss0 = hold_v_q[0] & ~bus.i_be_stall & (cnt_q != '0) & ~bus.i_flush & ~i_rst;
    w_iss1 = w_iss0 & hold_v_q[1] & (cnt_q >= C_TWO);
    // h1 is never valid alone, so an empty h0 means the hold is empty
    w_drain   = (~hold_v_q[0] | w_iss0) & (~hold_v_q[1] | w_iss1);
    w_dequeue = w_drain & ~bus.i_flush & ~i_rst;

    w_cnt_sum = {1'b0, cnt_q} - (CNT_W + 1)'(w_iss0) - (CNT_W + 1)'(w_iss1)
              + (CNT_W + 1)'(bus.i_credit_ret);
    cnt_d     = (w_cnt_sum > C_CREDITS_EXT) ? C_CREDITS : w_cnt_sum[CNT_W-1:0];

    hold_v_d  = hold_v_q;
    hold_pl_d = hold_pl_q;
    if (bus.i_flush) begin
      hold_v_d = 2'b00;
    end else if (w_dequeue) begin
      if (bus.i_instrs[0][0]) begin
        hold_v_d     = {bus.i_instrs[1][0], 1'b1};
        hold_pl_d[0] = bus.i_instrs[0][DATA_W:1];
        hold_pl_d[1] = bus.i_instrs[1][DATA_W:1];
      end else begin
        // Compact a lone lane-1 instruction into h0
        hold_v_d     = {1'b0, bus.i_instrs[1][0]};
        hold_pl_d[0] = bus.i_instrs[1][DATA_W:1];
      end
    end else if (w_iss0 & ~w_iss1 & hold_v_q[1]) begin
      hold_v_d     = 2'b01;
      hold_pl_d[0] = hold_pl_q[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_v_q <= 2'b00;
      cnt_q    <= C_CREDITS;
    end else begin
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
    end
    hold_pl_q <= hold_pl_d;
  end

  // The backend must never return more entries than it holds
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (w_cnt_sum <= C_CREDITS_EXT);
    end
  end

  assign bus.o_instrs[0] = {hold_pl_q[0], w_iss0};
  assign bus.o_instrs[1] = {hold_pl_q[1], w_iss1};
  assign bus.o_dequeue   = w_dequeue;
  assign bus.o_credits   = cnt_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_disp_q, stat_disp_d;
  logic [31:0] stat_cstall_q, stat_cstall_d;

  always_comb begin
    stat_disp_d   = stat_disp_q + 32'(w_iss0) + 32'(w_iss1);
    stat_cstall_d = stat_cstall_q
                  + 32'(hold_v_q[0] & ~bus.i_be_stall & ~bus.i_flush & (cnt_q == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_disp_q   <= '0;
      stat_cstall_q <= '0;
    end else begin
      stat_disp_q   <= stat_disp_d;
      stat_cstall_q <= stat_cstall_d;
    end
  end

  assign o_stat_disp   = stat_disp_q;
  assign o_stat_cstall = stat_cstall_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_instr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_dispatch
// Purpose  : Directed scenarios plus randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_dispatch;
  localparam int DATA_W  = 64;
  localparam int CREDITS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_dispatch_if #(.DATA_W(DATA_W), .CREDITS(CREDITS)) bus();

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_disp, stat_cstall;
`endif

  instr_dispatch #(.DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef DISPATCH_STATS_EN
    ,
    .o_stat_disp   (stat_disp),
    .o_stat_cstall (stat_cstall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic set_in(input logic v0, input logic [DATA_W-1:0] p0,
                        input logic v1, input logic [DATA_W-1:0] p1,
                        input logic fl, input logic st, input logic [1:0] ret);
    bus.i_instrs[0]  = {p0, v0};
    bus.i_instrs[1]  = {p1, v1};
    bus.i_flush      = fl;
    bus.i_be_stall   = st;
    bus.i_credit_ret = ret;
  endtask

  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, '0, 0, '0, 0, 0, 2'd0);
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 64'h1111, 1, 64'h2222, 0, 0, 2'd0);
    advance();
    #1;
    checks++; if (bus.o_dequeue !== 1'b0) begin errors++; $display("FAIL rst_deq got %b exp 0", bus.o_dequeue); end
    checks++; if ({bus.o_instrs[1][0], bus.o_instrs[0][0]} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b%b exp 00", bus.o_instrs[1][0], bus.o_instrs[0][0]); end
    checks++; if (bus.o_credits !== 4'd8) begin errors++; $display("FAIL rst_credits got %0d exp 8", bus.o_credits); end
    advance();
    rst = 1'b0;
    set_in(0, '0, 0, '0, 0, 0, 2'd0);
    #1;
    checks++; if (bus.o_dequeue !== 1'b1) begin errors++; $display("FAIL rst_empty_deq got %b exp 1", bus.o_dequeue); end
    checks++; if (bus.o_instrs[0][0] !== 1'b0) begin errors++; $display("FAIL rst_empty_v0 got %b exp 0", bus.o_instrs[0][0]); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] a, b;
    a = 64'hA0A0_0000_0000_000A; b = 64'hB0B0_0000_0000_000B;
    do_reset();
    set_in(1, a, 1, b, 0, 0, 2'd0); #1;
    checks++; if (bus.o_dequeue !== 1'b1) begin errors++; $display("FAIL basic_deq0 got %b exp 1", bus.o_dequeue); end
    checks++; if (bus.o_instrs[0][0] !== 1'b0) begin errors++; $display("FAIL basic_v0_c0 got %b exp 0", bus.o_instrs[0][0]); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if (bus.o_instrs[0] !== {a, 1'b1}) begin errors++; $display("FAIL basic_lane0 got %h exp %h", bus.o_instrs[0], {a, 1'b1}); end
    checks++; if (bus.o_instrs[1] !== {b, 1'b1}) begin errors++; $display("FAIL basic_lane1 got %h exp %h", bus.o_instrs[1], {b, 1'b1}); end
    checks++; if (bus.o_credits !== 4'd8) begin errors++; $display("FAIL basic_cred_c1 got %0d exp 8", bus.o_credits); end
    advance(); #1;
    checks++; if (bus.o_credits !== 4'd6) begin errors++; $display("FAIL basic_cred_c2 got %0d exp 6", bus.o_credits); end
  endtask

  task automatic test_partial();
    logic [DATA_W-1:0] a, b, e, f;
    a = 64'hA1; b = 64'hB1; e = 64'hE1; f = 64'hF1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 64'(100 + 2 * i), 1, 64'(101 + 2 * i), 0, 0, 2'd0);
      advance();
    end
    set_in(1, 64'h55, 0, '0, 0, 0, 2'd0); advance();
    set_in(1, a, 1, b, 0, 0, 2'd0); advance();
    set_in(1, e, 1, f, 0, 0, 2'd1); #1;
    checks++; if (bus.o_credits !== 4'd1) begin errors++; $display("FAIL part_cred1 got %0d exp 1", bus.o_credits); end
    checks++; if (bus.o_instrs[0] !== {a, 1'b1}) begin errors++; $display("FAIL part_laneA got %h exp %h", bus.o_instrs[0], {a, 1'b1}); end
    checks++; if (bus.o_instrs[1][0] !== 1'b0) begin errors++; $display("FAIL part_lane1_v got %b exp 0", bus.o_instrs[1][0]); end
    checks++; if (bus.o_dequeue !== 1'b0) begin errors++; $display("FAIL part_deq_t got %b exp 0", bus.o_dequeue); end
    advance();
    set_in(1, e, 1, f, 0, 0, 2'd0); #1;
    checks++; if (bus.o_credits !== 4'd1) begin errors++; $display("FAIL part_cred_t1 got %0d exp 1", bus.o_credits); end
    checks++; if (bus.o_instrs[0] !== {b, 1'b1}) begin errors++; $display("FAIL part_laneB got %h exp %h", bus.o_instrs[0], {b, 1'b1}); end
    checks++; if (bus.o_dequeue !== 1'b1) begin errors++; $display("FAIL part_deq_t1 got %b exp 1", bus.o_dequeue); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd2); #1;
    checks++; if (bus.o_credits !== 4'd0) begin errors++; $display("FAIL zero_cred got %0d exp 0", bus.o_credits); end
    checks++; if ({bus.o_instrs[0][0], bus.o_dequeue} !== 2'b00) begin errors++; $display("FAIL zero_block got v0/deq %b%b exp 00", bus.o_instrs[0][0], bus.o_dequeue); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if (bus.o_instrs[0] !== {e, 1'b1} || bus.o_instrs[1] !== {f, 1'b1}) begin errors++; $display("FAIL zero_resume got %h %h exp %h %h", bus.o_instrs[0], bus.o_instrs[1], {e, 1'b1}, {f, 1'b1}); end
    advance();
  endtask

  task automatic test_compact();
    logic [DATA_W-1:0] c;
    c = 64'hC0FF_EE00_1234_5678;
    do_reset();
    set_in(0, 64'hDEAD, 1, c, 0, 0, 2'd0); #1;
    checks++; if (bus.o_dequeue !== 1'b1) begin errors++; $display("FAIL comp_deq got %b exp 1", bus.o_dequeue); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if (bus.o_instrs[0] !== {c, 1'b1}) begin errors++; $display("FAIL comp_lane0 got %h exp %h", bus.o_instrs[0], {c, 1'b1}); end
    checks++; if (bus.o_instrs[1][0] !== 1'b0) begin errors++; $display("FAIL comp_lane1_v got %b exp 0", bus.o_instrs[1][0]); end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 64'h10, 1, 64'h11, 0, 0, 2'd0); advance();
    set_in(1, 64'h12, 1, 64'h13, 0, 0, 2'd0); advance();
    set_in(1, 64'h14, 1, 64'h15, 1, 0, 2'd0); #1;
    checks++; if ({bus.o_instrs[1][0], bus.o_instrs[0][0], bus.o_dequeue} !== 3'b000) begin errors++; $display("FAIL flush_cycle got v1/v0/deq %b%b%b exp 000", bus.o_instrs[1][0], bus.o_instrs[0][0], bus.o_dequeue); end
    checks++; if (bus.o_credits !== 4'd6) begin errors++; $display("FAIL flush_cred0 got %0d exp 6", bus.o_credits); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if ({bus.o_instrs[0][0], bus.o_dequeue} !== 2'b01) begin errors++; $display("FAIL flush_empty got v0/deq %b%b exp 01", bus.o_instrs[0][0], bus.o_dequeue); end
    checks++; if (bus.o_credits !== 4'd6) begin errors++; $display("FAIL flush_cred1 got %0d exp 6", bus.o_credits); end
    advance();
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] a, b, e, f;
    a = 64'hA5; b = 64'hB5; e = 64'hE5; f = 64'hF5;
    do_reset();
    set_in(1, a, 1, b, 0, 0, 2'd0); advance();
    for (int i = 0; i < 3; i++) begin
      set_in(1, e, 1, f, 0, 1, 2'd0); #1;
      checks++; if ({bus.o_instrs[1][0], bus.o_instrs[0][0], bus.o_dequeue} !== 3'b000) begin errors++; $display("FAIL stall_c%0d got v1/v0/deq %b%b%b exp 000", i, bus.o_instrs[1][0], bus.o_instrs[0][0], bus.o_dequeue); end
      advance();
    end
    set_in(1, e, 1, f, 0, 0, 2'd0); #1;
    checks++; if (bus.o_instrs[0] !== {a, 1'b1} || bus.o_instrs[1] !== {b, 1'b1}) begin errors++; $display("FAIL stall_release got %h %h exp %h %h", bus.o_instrs[0], bus.o_instrs[1], {a, 1'b1}, {b, 1'b1}); end
    checks++; if (bus.o_dequeue !== 1'b1) begin errors++; $display("FAIL stall_rel_deq got %b exp 1", bus.o_dequeue); end
    advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if (bus.o_instrs[0] !== {e, 1'b1} || bus.o_credits !== 4'd6) begin errors++; $display("FAIL stall_next got %h cred %0d exp %h cred 6", bus.o_instrs[0], bus.o_credits, {e, 1'b1}); end
    advance();
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    checks++; if (stat_disp !== 32'd0 || stat_cstall !== 32'd0) begin errors++; $display("FAIL stats_rst0 got %0d %0d exp 0 0", stat_disp, stat_cstall); end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 64'(200 + 2 * i), 1, 64'(201 + 2 * i), 0, 0, 2'd0);
      advance();
    end
    set_in(0, '0, 0, '0, 0, 0, 2'd0); advance();
    advance();
    set_in(0, '0, 0, '0, 0, 1, 2'd0); advance();
    set_in(0, '0, 0, '0, 1, 0, 2'd0); advance();
    set_in(0, '0, 0, '0, 0, 0, 2'd0); #1;
    checks++; if (stat_disp !== 32'd8) begin errors++; $display("FAIL stats_disp got %0d exp 8", stat_disp); end
    checks++; if (stat_cstall !== 32'd2) begin errors++; $display("FAIL stats_cstall got %0d exp 2", stat_cstall); end
    do_reset();
    #1;
    checks++; if (stat_disp !== 32'd0 || stat_cstall !== 32'd0) begin errors++; $display("FAIL stats_rst1 got %0d %0d exp 0 0", stat_disp, stat_cstall); end
  endtask
`endif

  task automatic test_random();
    logic [DATA_W-1:0] hq[$];
    int cr, n, room, disp_m, cst_m;
    logic r, fl, st, v0, v1, exp_deq;
    logic [DATA_W-1:0] p0, p1;
    logic [1:0] ret;
    do_reset();
    hq.delete();
    cr = CREDITS; disp_m = 0; cst_m = 0;
    repeat (3000) begin
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 4) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      p0 = {$urandom, $urandom};
      p1 = {$urandom, $urandom};
      n = (r || fl || st) ? 0 : hq.size();
      if (n > cr) n = cr;
      if (n > 2) n = 2;
      room = CREDITS - (cr - n);
      if (room > 2) room = 2;
      ret = (r || $urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, room));
      exp_deq = !r && !fl && (n == hq.size());
      rst = r;
      set_in(v0, p0, v1, p1, fl, st, ret);
      #1;
      checks++; if (bus.o_credits !== 4'(cr)) begin errors++; $display("FAIL rnd_credits got %0d exp %0d", bus.o_credits, cr); end
      checks++; if (bus.o_dequeue !== exp_deq) begin errors++; $display("FAIL rnd_deq got %b exp %b", bus.o_dequeue, exp_deq); end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (bus.o_instrs[k][0] !== (k < n)) begin
          errors++; $display("FAIL rnd_valid%0d got %b exp %b", k, bus.o_instrs[k][0], (k < n));
        end else if (k < n && bus.o_instrs[k][DATA_W:1] !== hq[k]) begin
          errors++; $display("FAIL rnd_payload%0d got %h exp %h", k, bus.o_instrs[k][DATA_W:1], hq[k]);
        end
      end
`ifdef DISPATCH_STATS_EN
      checks++; if (stat_disp !== 32'(disp_m) || stat_cstall !== 32'(cst_m)) begin errors++; $display("FAIL rnd_stats got %0d %0d exp %0d %0d", stat_disp, stat_cstall, disp_m, cst_m); end
`endif
      if (r) begin
        hq.delete();
        cr = CREDITS; disp_m = 0; cst_m = 0;
      end else begin
        if (hq.size() > 0 && !st && !fl && cr == 0) cst_m++;
        disp_m += n;
        repeat (n) void'(hq.pop_front());
        if (fl) hq.delete();
        else if (exp_deq) begin
          if (v0) hq.push_back(p0);
          if (v1) hq.push_back(p1);
        end
        cr = cr - n + int'(ret);
        if (cr > CREDITS) cr = CREDITS;
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, '0, 0, '0, 0, 0, 2'd0);
    @(negedge clk); #1;
    test_reset();
    test_basic();
    test_partial();
    test_compact();
    test_flush();
    test_stall();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
